// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU request arbiter: FSM states, operand field layout
// and response status bit positions.
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam int BIAS   = 31;
    localparam int EXP_W  = 6;
    localparam int MANT_W = 25;
    localparam int WORD_W = 1 + EXP_W + MANT_W;

    localparam int STAT_W       = 4;
    localparam int STAT_TMO_BIT = 3;
    localparam int STAT_FPU_MSB = 2;

    localparam logic [STAT_W-1:0] STATUS_TIMEOUT = STAT_W'(1) << STAT_TMO_BIT;
    localparam logic [STAT_W-1:0] STATUS_CORE_MASK = STAT_W'((1 << (STAT_FPU_MSB + 1)) - 1);

    // Core status as reported to a requester: timeout bit forced clear.
    function automatic logic [STAT_W-1:0] core_status(input logic [STAT_W-1:0] raw);
        return raw & STATUS_CORE_MASK;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. On a tie the requester not granted last wins;
// last_grant resets to 1 so requester 0 takes the first tie.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic       enable,
    input  logic       update,
    output logic [1:0] grant,
    output logic       gnt_id
);

    logic last_grant_reg;
    logic last_grant_next;

    always_comb begin
        gnt_id = 1'b0;
        unique case (req_valid)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last_grant_reg;
            default: gnt_id = 1'b0;
        endcase
        grant = 2'b00;
        if (enable && (req_valid != 2'b00)) begin
            grant = gnt_id ? 2'b10 : 2'b01;
        end
        last_grant_next = update ? gnt_id : last_grant_reg;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_reg <= 1'b1;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Arbitrates two requesters onto a single external FPU core, one operation in
// flight, with a WAIT-state timeout that aborts a stuck core.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [3:0]       rsp_status,
    output logic             fpu_start,
    output logic [31:0]      fpu_op_a,
    output logic [31:0]      fpu_op_b,
    input  logic             fpu_done,
    input  logic [31:0]      fpu_data,
    input  logic [3:0]       fpu_status,
    output logic             fpu_abort,
    output logic [CNT_W-1:0] op_count
);

    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    arb_state_e          state_reg, state_next;
    logic [WORD_W-1:0]   op_a_reg, op_b_reg;
    logic                gnt_id_reg;
    logic [TMO_W-1:0]    tmo_cnt_reg;
    logic [WORD_W-1:0]   rsp_data_reg;
    logic [STAT_W-1:0]   rsp_status_reg;
    logic [CNT_W-1:0]    op_count_reg;

    logic [1:0]          arb_grant;
    logic                arb_gnt_id;
    logic [1:0]          req_fire;
    logic [1:0]          rsp_fire;
    logic                accept;
    logic                capture;
    logic                timeout;
    logic                rsp_take;

    // Grant is only offered in IDLE and never while reset is held.
    rr_arb2 u_rr_arb2 (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .enable    ((state_reg == ST_IDLE) && reset),
        .update    (accept),
        .grant     (arb_grant),
        .gnt_id    (arb_gnt_id)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign req_ready[gi] = arb_grant[gi];
            assign req_fire[gi]  = req_valid[gi] & arb_grant[gi];
            assign rsp_valid[gi] = (state_reg == ST_RESP) && (gnt_id_reg == 1'(gi));
            assign rsp_fire[gi]  = rsp_valid[gi] & rsp_ready[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        fpu_start  = 1'b0;
        fpu_abort  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        rsp_take   = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (|req_fire) begin
                    accept     = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fpu_start  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion on the final WAIT cycle beats the timeout.
                if (fpu_done) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    timeout    = 1'b1;
                    fpu_abort  = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (|rsp_fire) begin
                    rsp_take   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            gnt_id_reg     <= 1'b0;
            tmo_cnt_reg    <= '0;
            rsp_data_reg   <= '0;
            rsp_status_reg <= '0;
            op_count_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_a_reg   <= arb_gnt_id ? req1_a : req0_a;
                op_b_reg   <= arb_gnt_id ? req1_b : req0_b;
                gnt_id_reg <= arb_gnt_id;
            end
            if (state_reg == ST_ISSUE) begin
                tmo_cnt_reg <= '0;
            end else if (state_reg == ST_WAIT) begin
                tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
            end
            if (capture) begin
                rsp_data_reg   <= fpu_data;
                rsp_status_reg <= core_status(fpu_status);
            end else if (timeout) begin
                rsp_data_reg   <= '0;
                rsp_status_reg <= STATUS_TIMEOUT;
            end
            if (rsp_take) begin
                op_count_reg <= op_count_reg + CNT_W'(1);
            end
        end
    end

    assign fpu_op_a   = op_a_reg;
    assign fpu_op_b   = op_b_reg;
    assign rsp_data   = rsp_data_reg;
    assign rsp_status = rsp_status_reg;
    assign op_count   = op_count_reg;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed, table-driven bench for fpu_arbiter; a second instance with a 4-bit
// counter shares the stimulus so counter wrap is reachable in a short run.
module tb_fpu_arbiter;

    localparam int TMO = 64;

    logic        clock;
    logic        reset;
    logic [1:0]  req_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  rsp_ready;
    logic        fpu_done;
    logic [31:0] fpu_data;
    logic [3:0]  fpu_status;

    logic [1:0]  req_ready, rsp_valid;
    logic [31:0] rsp_data, fpu_op_a, fpu_op_b;
    logic [3:0]  rsp_status;
    logic        fpu_start, fpu_abort;
    logic [15:0] op_count;

    logic [1:0]  req_ready_s, rsp_valid_s;
    logic [31:0] rsp_data_s, fpu_op_a_s, fpu_op_b_s;
    logic [3:0]  rsp_status_s;
    logic        fpu_start_s, fpu_abort_s;
    logic [3:0]  op_count_s;

    int n_vec  = 0;
    int n_miss = 0;
    int cnt_model = 0;

    fpu_arbiter #(.TIMEOUT_CYC(TMO), .CNT_W(16)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_status(rsp_status),
        .fpu_start(fpu_start), .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b),
        .fpu_done(fpu_done), .fpu_data(fpu_data), .fpu_status(fpu_status),
        .fpu_abort(fpu_abort), .op_count(op_count)
    );

    fpu_arbiter #(.TIMEOUT_CYC(TMO), .CNT_W(4)) u_dut_w (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_s),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_s), .rsp_status(rsp_status_s),
        .fpu_start(fpu_start_s), .fpu_op_a(fpu_op_a_s), .fpu_op_b(fpu_op_b_s),
        .fpu_done(fpu_done), .fpu_data(fpu_data), .fpu_status(fpu_status),
        .fpu_abort(fpu_abort_s), .op_count(op_count_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] a0, b0, a1, b1;
        int          wait_n;     // WAIT cycle carrying fpu_done; 0 = core never answers
        logic [31:0] cdata;
        logic [3:0]  cstat;
        int          hold;       // cycles rsp_ready withheld
        bit          stray;      // fpu_done pulse during ISSUE, must be ignored
        int          exp_g;
        logic [31:0] exp_data;
        logic [3:0]  exp_stat;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic [1:0] rv, input logic [31:0] a0, input logic [31:0] b0,
                                input logic [31:0] a1, input logic [31:0] b1, input int wait_n,
                                input logic [31:0] cdata, input logic [3:0] cstat, input int hold,
                                input bit stray, input int exp_g, input logic [31:0] exp_data,
                                input logic [3:0] exp_stat);
        vec_t v;
        v.rv = rv; v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
        v.wait_n = wait_n; v.cdata = cdata; v.cstat = cstat; v.hold = hold;
        v.stray = stray; v.exp_g = exp_g; v.exp_data = exp_data; v.exp_stat = exp_stat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [1:0]  g_oh;
        logic [31:0] ea, eb;
        int aborts, early, unstable;
        g_oh = (v.exp_g == 1) ? 2'b10 : 2'b01;
        ea = (v.exp_g == 1) ? v.a1 : v.a0;
        eb = (v.exp_g == 1) ? v.b1 : v.b0;

        @(negedge clock);
        req_valid = v.rv; req0_a = v.a0; req0_b = v.b0; req1_a = v.a1; req1_b = v.b1;
        rsp_ready = 2'b00; fpu_done = 1'b0;
        #1;
        chk("grant_req_ready", 32'(req_ready), 32'(g_oh));

        @(negedge clock);
        req_valid = 2'b00;
        if (v.stray) begin
            fpu_done = 1'b1; fpu_data = 32'hDEAD_BEEF; fpu_status = 4'hF;
        end
        #1;
        chk("issue_fpu_start", 32'(fpu_start), 32'd1);
        chk("issue_op_a", fpu_op_a, ea);
        chk("issue_op_b", fpu_op_b, eb);

        aborts = 0; early = 0;
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clock);
            fpu_done = 1'b0;
            if (k == v.wait_n) begin
                fpu_done = 1'b1; fpu_data = v.cdata; fpu_status = v.cstat;
            end
            #1;
            if (fpu_abort) aborts++;
            if (rsp_valid != 2'b00 || fpu_start || req_ready != 2'b00) early++;
            if (k == v.wait_n) break;
        end
        chk("wait_abort_pulses", 32'(aborts), (v.wait_n == 0) ? 32'd1 : 32'd0);
        chk("wait_quiet_outputs", 32'(early), 32'd0);

        @(negedge clock);
        fpu_done = 1'b0;
        #1;
        chk("resp_latency_valid", 32'(rsp_valid), 32'(g_oh));
        chk("resp_data", rsp_data, v.exp_data);
        chk("resp_status", 32'(rsp_status), 32'(v.exp_stat));

        unstable = 0;
        for (int h = 0; h < v.hold; h++) begin
            rsp_ready = ~g_oh;
            req_valid = 2'b11;
            @(negedge clock);
            #1;
            if (rsp_valid != g_oh || rsp_data != v.exp_data || rsp_status != v.exp_stat
                || req_ready != 2'b00 || fpu_start) unstable++;
        end
        if (v.hold > 0) chk("resp_hold_stable", 32'(unstable), 32'd0);

        rsp_ready = g_oh;
        req_valid = 2'b00;
        @(negedge clock);
        rsp_ready = 2'b00;
        #1;
        cnt_model++;
        chk("done_rsp_valid_low", 32'(rsp_valid), 32'd0);
        chk("op_count", 32'(op_count), 32'(cnt_model[15:0]));
        chk("op_count_narrow", 32'(op_count_s), 32'(cnt_model[3:0]));
    endtask

    initial begin
        vecs[0]  = mk(2'b01, 32'h3E00_0000, 32'h3E00_0000, 32'h0, 32'h0, 3,
                      32'h4000_0000, 4'h0, 0, 1'b0, 0, 32'h4000_0000, 4'h0);
        vecs[1]  = mk(2'b11, 32'hA0A0_0001, 32'hB0B0_0001, 32'hA1A1_0001, 32'hB1B1_0001, 1,
                      32'h1111_1111, 4'hB, 0, 1'b0, 1, 32'h1111_1111, 4'h3);
        vecs[2]  = mk(2'b11, 32'hA0A0_0002, 32'hB0B0_0002, 32'hA1A1_0002, 32'hB1B1_0002, 2,
                      32'h2222_2222, 4'h5, 0, 1'b1, 0, 32'h2222_2222, 4'h5);
        vecs[3]  = mk(2'b11, 32'hA0A0_0003, 32'hB0B0_0003, 32'hA1A1_0003, 32'hB1B1_0003, 0,
                      32'hFFFF_FFFF, 4'h7, 0, 1'b0, 1, 32'h0000_0000, 4'h8);
        vecs[4]  = mk(2'b10, 32'hA0A0_0004, 32'hB0B0_0004, 32'hA1A1_0004, 32'hB1B1_0004, 64,
                      32'h3333_3333, 4'h1, 0, 1'b0, 1, 32'h3333_3333, 4'h1);
        vecs[5]  = mk(2'b11, 32'hA0A0_0005, 32'hB0B0_0005, 32'hA1A1_0005, 32'hB1B1_0005, 1,
                      32'h4444_4444, 4'h2, 10, 1'b0, 0, 32'h4444_4444, 4'h2);
        vecs[6]  = mk(2'b01, 32'hA0A0_0006, 32'hB0B0_0006, 32'hA1A1_0006, 32'hB1B1_0006, 5,
                      32'h5555_5555, 4'h0, 0, 1'b0, 0, 32'h5555_5555, 4'h0);
        vecs[7]  = mk(2'b10, 32'hA0A0_0007, 32'hB0B0_0007, 32'hA1A1_0007, 32'hB1B1_0007, 2,
                      32'h6666_6666, 4'hF, 0, 1'b0, 1, 32'h6666_6666, 4'h7);
        vecs[8]  = mk(2'b11, 32'hC0C0_0008, 32'hD0D0_0008, 32'hC1C1_0008, 32'hD1D1_0008, 1,
                      32'h7777_7777, 4'h0, 0, 1'b0, 0, 32'h7777_7777, 4'h0);
        vecs[9]  = mk(2'b11, 32'hC0C0_0009, 32'hD0D0_0009, 32'hC1C1_0009, 32'hD1D1_0009, 1,
                      32'h8888_8888, 4'h0, 0, 1'b0, 1, 32'h8888_8888, 4'h0);
        vecs[10] = mk(2'b11, 32'hC0C0_000A, 32'hD0D0_000A, 32'hC1C1_000A, 32'hD1D1_000A, 1,
                      32'h9999_9999, 4'h0, 0, 1'b0, 0, 32'h9999_9999, 4'h0);

        reset = 1'b0;
        req_valid = 2'b11; rsp_ready = 2'b00;
        req0_a = 32'h1; req0_b = 32'h2; req1_a = 32'h3; req1_b = 32'h4;
        fpu_done = 1'b1; fpu_data = 32'h1234_5678; fpu_status = 4'hF;
        repeat (3) @(negedge clock);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_status", 32'(rsp_status), 32'd0);
        chk("reset_fpu_start", 32'(fpu_start), 32'd0);
        chk("reset_fpu_abort", 32'(fpu_abort), 32'd0);
        chk("reset_op_a", fpu_op_a, 32'd0);
        chk("reset_op_count", 32'(op_count), 32'd0);

        @(negedge clock);
        req_valid = 2'b00; fpu_done = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            $display("vector %0d: rv=%b wait=%0d hold=%0d exp_g=%0d", i, vecs[i].rv,
                     vecs[i].wait_n, vecs[i].hold, vecs[i].exp_g);
            run_vec(vecs[i]);
        end

        // Push the narrow instance's counter through its wrap point.
        for (int i = 0; i < 8; i++) begin
            $display("wrap op %0d", i);
            run_vec(mk(2'b01, 32'h1000_0000 + i, 32'h2000_0000 + i, 32'h0, 32'h0, 1,
                       32'h5000_0000 + i, 4'h0, 0, 1'b0, 0, 32'h5000_0000 + i, 4'h0));
        end
        chk("wrap_op_count_16", 32'(op_count), 32'd16);
        chk("wrap_narrow_zero", 32'(op_count_s), 32'd0);

        // Reset in the middle of WAIT drops the operation.
        $display("reset mid-WAIT sequence");
        @(negedge clock);
        req_valid = 2'b10; req1_a = 32'hE1E1_0000; req1_b = 32'hE2E2_0000;
        #1;
        chk("midrst_grant", 32'(req_ready), 32'b10);
        @(negedge clock);
        req_valid = 2'b00;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_fpu_start", 32'(fpu_start), 32'd0);
        chk("midrst_fpu_abort", 32'(fpu_abort), 32'd0);
        chk("midrst_op_a", fpu_op_a, 32'd0);
        chk("midrst_op_b", fpu_op_b, 32'd0);
        chk("midrst_op_count", 32'(op_count), 32'd0);
        cnt_model = 0;
        @(negedge clock);
        reset = 1'b1;
        begin
            int stray_rsp;
            stray_rsp = 0;
            for (int i = 0; i < 70; i++) begin
                @(negedge clock);
                #1;
                if (rsp_valid != 2'b00 || fpu_abort || fpu_start) stray_rsp++;
            end
            chk("midrst_no_response", 32'(stray_rsp), 32'd0);
        end
        chk("midrst_count_stays", 32'(op_count), 32'd0);

        for (int i = 8; i < 11; i++) begin
            $display("vector %0d: rv=%b wait=%0d hold=%0d exp_g=%0d", i, vecs[i].rv,
                     vecs[i].wait_n, vecs[i].hold, vecs[i].exp_g);
            run_vec(vecs[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
